// File: rtl/pc_watch_dump_sequencer.sv
// pc_watch_dump_sequencer
//
// Sits beside the pipelined MIPS core. It compares the fetch PC against
// NUM_WP programmable watchpoints, counts the cycles spent running and
// enforces an optional cycle timeout. When a watchpoint hits or the timeout
// expires, it reads a window of data memory one word at a time and streams
// the words out over a valid/ready interface.
//
// Optional feature: define DUMP_CHECKSUM_EN to add a `checksum` output and
// an extra closing beat that carries the running sum of the dumped words.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   pc/pc_valid  fetch PC tap and its qualifier
//   wp_addr      packed watchpoint addresses, entry k at [k*ADDR_W +: ADDR_W]
//   wp_en        per-watchpoint enable
//   mem_rd       data memory read strobe (high only in the read cycle)
//   mem_addr     data memory word index
//   mem_rdata    read data, valid one cycle after mem_rd
//   dump_data    streamed word
//   dump_valid   dump_data is valid
//   dump_ready   consumer accepts the current word
//   dump_last    final beat of the stream
//   hit_id       index of the watchpoint that fired
//   timed_out    dump was started by the timeout
//   cycle_count  cycles spent running, saturating, frozen once the dump starts
//   done         dump complete, sticky until reset
//   checksum     (DUMP_CHECKSUM_EN only) sum of accepted data words
`timescale 1ns/1ps

module pc_watch_dump_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_AW     = 10,
  parameter int NUM_WP     = 2,
  parameter int DUMP_BASE  = 32,
  parameter int DUMP_LEN   = 96,
  parameter int MAX_CYCLES = 100000,
  localparam int HID_W     = (NUM_WP > 32'sd1) ? $clog2(NUM_WP) : 32'sd1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     pc_valid,
  input  logic [NUM_WP*ADDR_W-1:0] wp_addr,
  input  logic [NUM_WP-1:0]        wp_en,
  output logic                     mem_rd,
  output logic [MEM_AW-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic                     dump_last,
  output logic [HID_W-1:0]         hit_id,
  output logic                     timed_out,
  output logic [31:0]              cycle_count,
  output logic                     done
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]        checksum
`endif
);

  localparam logic [MEM_AW-1:0] BASE_IDX = MEM_AW'(DUMP_BASE);
  localparam logic [MEM_AW-1:0] LAST_IDX = MEM_AW'(DUMP_LEN - 32'sd1);
  localparam logic              TO_EN    = (MAX_CYCLES != 32'sd0);
  localparam logic [31:0]       TO_LAST  = TO_EN ? 32'(MAX_CYCLES - 32'sd1) : 32'd0;

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_OUT  = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state;
  logic [MEM_AW-1:0] idx;

  logic [NUM_WP-1:0] match;
  logic              hit;
  logic [HID_W-1:0]  hit_k;
  logic              timeout;
  logic [MEM_AW-1:0] next_idx;
  logic [MEM_AW-1:0] next_addr;

  // Watchpoint compare with lowest-index priority, timeout detect, next index.
  always_comb begin
    match   = '0;
    hit     = 1'b0;
    hit_k   = '0;
    for (int k = 0; k < NUM_WP; k++) begin
      match[k] = pc_valid & wp_en[k] & (pc == wp_addr[k*ADDR_W +: ADDR_W]);
    end
    for (int k = 0; k < NUM_WP; k++) begin
      if (match[k] && !hit) begin
        hit   = 1'b1;
        hit_k = HID_W'(k);
      end else begin
        hit   = hit;
        hit_k = hit_k;
      end
    end
    // A hit in the same cycle as the timeout takes precedence.
    timeout   = TO_EN && (cycle_count == TO_LAST) && !hit;
    next_idx  = idx + MEM_AW'(1);
    // Addition is MEM_AW bits wide, so the window wraps at the top of memory.
    next_addr = BASE_IDX + next_idx;
  end

  // Sequencer FSM: run/watch, then read -> capture -> output per word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_RUN;
      idx         <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      dump_data   <= '0;
      dump_valid  <= 1'b0;
      dump_last   <= 1'b0;
      hit_id      <= '0;
      timed_out   <= 1'b0;
      cycle_count <= 32'd0;
      done        <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      case (state)
        S_RUN: begin
          if (cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
          end else begin
            cycle_count <= cycle_count;
          end
          if (hit) begin
            hit_id    <= hit_k;
            timed_out <= 1'b0;
            idx       <= '0;
            mem_rd    <= 1'b1;
            mem_addr  <= BASE_IDX;
            state     <= S_RD;
          end else if (timeout) begin
            hit_id    <= '0;
            timed_out <= 1'b1;
            idx       <= '0;
            mem_rd    <= 1'b1;
            mem_addr  <= BASE_IDX;
            state     <= S_RD;
          end else begin
            state     <= S_RUN;
          end
        end
        S_RD: begin
          // Memory returns the word during the following cycle.
          mem_rd <= 1'b0;
          state  <= S_CAP;
        end
        S_CAP: begin
          dump_data  <= mem_rdata;
          dump_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          // The checksum beat closes the stream, not the last data word.
          dump_last  <= 1'b0;
`else
          dump_last  <= (idx == LAST_IDX);
`endif
          state      <= S_OUT;
        end
        S_OUT: begin
          if (dump_valid && dump_ready) begin
            dump_valid <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            checksum <= checksum + dump_data;
            if (idx == LAST_IDX) begin
              dump_data  <= checksum + dump_data;
              dump_valid <= 1'b1;
              dump_last  <= 1'b1;
              state      <= S_CSUM;
            end else begin
              idx      <= next_idx;
              mem_rd   <= 1'b1;
              mem_addr <= next_addr;
              state    <= S_RD;
            end
`else
            if (dump_last) begin
              dump_last <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              idx      <= next_idx;
              mem_rd   <= 1'b1;
              mem_addr <= next_addr;
              state    <= S_RD;
            end
`endif
          end else begin
            state <= S_OUT;
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (dump_valid && dump_ready) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            state <= S_CSUM;
          end
        end
`endif
        S_DONE: begin
          done       <= 1'b1;
          mem_rd     <= 1'b0;
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
        end
        default: begin
          // Unreachable encoding: silence all strobes and resume watching.
          mem_rd     <= 1'b0;
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
          state      <= S_RUN;
        end
      endcase
    end
  end

endmodule
